fifo_flex: RTL and testbench
============================

FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 Parameter DW, default 16, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of entries (>=2, any integer, not restricted to a power of 2).
REQ-003 Parameter AF_LVL, default DEPTH-1, almost_full threshold in entries.
REQ-004 Parameter AE_LVL, default 1, almost_empty threshold in entries.
REQ-005 Parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  in  1  single clock; all logic samples on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 clear  in  1  synchronous flush, active-high.
REQ-009 push  in  1  write request.
REQ-010 write_data  in  DW  write data.
REQ-011 pop  in  1  read request.
REQ-012 read_data  out  DW  read data.
REQ-013 full / empty  out  1 each  occupancy == DEPTH / occupancy == 0.
REQ-014 almost_full / almost_empty  out  1 each  count >= AF_LVL / count <= AE_LVL.
REQ-015 count  out  CW  occupancy 0..DEPTH, CW = $clog2(DEPTH+1).
REQ-016 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-017 Pop is accepted when pop=1 and empty=0.
REQ-018 Push is accepted when push=1 and either full=0, or full=1 with a pop accepted in the same cycle.
REQ-019 A push at full without an accepted pop is dropped, and overflow is set.
REQ-020 A pop at empty is ignored and sets underflow, including when push=1 in the same cycle.
REQ-021 A pop at empty does not bypass write_data to read_data.
REQ-022 count, full, empty, almost_full and almost_empty are registered and update on the edge where push/pop are accepted.
REQ-023 Simultaneous accepted push and pop leave count unchanged.
REQ-024 Write and read pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1, independent of power-of-2 DEPTH.
REQ-025 FWFT=0: read_data is registered and takes the head entry on the edge where a pop is accepted; it holds its value otherwise, including while empty.
REQ-026 FWFT=1: read_data shows the head entry whenever empty=0; a pop advances it on the same edge.
REQ-027 FWFT=1: read_data holds its last value while empty=1.
REQ-028 clear=1 sets both pointers and count to 0, empty=1 and full=0, and clears overflow and underflow.
REQ-029 clear has priority over push and pop in the same cycle.
REQ-030 clear does not change read_data or the memory contents.
REQ-031 overflow and underflow remain set until clear or reset.

Reset
REQ-032 rst=0 asynchronously forces: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (or 1 if AF_LVL==0), overflow=0, underflow=0, read_data=0.
REQ-033 Reset asserted mid-operation discards all stored entries.
REQ-034 Memory contents are not reset.
REQ-035 Reset deassertion is synchronised by the instantiating context; the block accepts push/pop from the first rising edge after rst=1.

Structure
REQ-036 Package fifo_pkg holds the CW/pointer-width helper function and the default parameter constants.
REQ-037 One sub-module, fifo_mem: DEPTH x DW storage with one synchronous write port and one combinational read port.
REQ-038 Pointer/count control and flags reside in fifo_flex.
REQ-039 Elaboration fails on illegal parameters: DEPTH<2, AF_LVL>DEPTH or AE_LVL>DEPTH.

Verification (DW=16, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-040 Fill/drain: push 1,2,3,4, then push 5 -> full=1, count=4, almost_full=1, overflow=1; pop x4 -> read_data 1,2,3,4 (FWFT=0, one edge after each pop), empty=1.
REQ-041 Pop at empty: after drain, pop once -> underflow=1, read_data stays 4, count stays 0.
REQ-042 Full pass-through: at full (1..4), push 9 and pop together -> read_data=1, count=4, overflow=0; further pops return 2,3,4,9.
REQ-043 Wrap-around: 10 interleaved push/pop pairs with data 10..19, DEPTH=3 build -> output order 10..19 with no loss; pointers wrap cleanly at the non-power-of-2 depth.
REQ-044 Clear and reset mid-operation: with 3 entries and overflow set, clear=1 with push=1 -> count=0, empty=1, overflow=0, push ignored; repeat with rst=0 mid-cycle -> outputs go to reset values before the next edge.
REQ-045 FWFT=1 build: push 7 -> read_data=7 the cycle after the push, with no pop; pop -> empty=1, read_data holds 7.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the fifo_flex slice.
package fifo_pkg;

  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_AE_LVL = 1;
  localparam int unsigned DEF_FWFT   = 0;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port, no reset.
module fifo_mem #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, registered flags, sticky error flags,
// and selectable registered-read or first-word-fall-through output.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 1,
  parameter int unsigned AE_LVL = DEF_AE_LVL,
  parameter int unsigned FWFT   = DEF_FWFT,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] write_data,
  input  logic          pop,
  output logic [DW-1:0] read_data,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW     = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic AF_RST        = (AF_LVL == 0);

  if (DW < 1 || DEPTH < 2 || AF_LVL > DEPTH || AE_LVL > DEPTH) begin : g_bad_params
    $fatal(1, "fifo_flex: illegal parameters DW=%0d DEPTH=%0d AF_LVL=%0d AE_LVL=%0d",
           DW, DEPTH, AF_LVL, AE_LVL);
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] count_nxt;
  logic [DW-1:0] head;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= bump(wr_ptr);
      if (pop_ok)  rd_ptr <= bump(rd_ptr);
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_full  <= (count_nxt >= CW'(AF_LVL));
      almost_empty <= (count_nxt <= CW'(AE_LVL));
      if (push && full && !pop_ok) overflow <= 1'b1;
      if (pop && empty)            underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok & ~clear),
    .waddr (wr_ptr),
    .wdata (write_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  if (FWFT != 0) begin : g_fwft
    // held tracks the visible head so the output freezes once the FIFO drains or is cleared.
    logic [DW-1:0] held;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        held <= '0;
      else if (!empty) held <= head;
    end

    always_comb read_data = empty ? held : head;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 read_data <= '0;
      else if (pop_ok && !clear) read_data <= head;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Drives three fifo_flex builds (depth 4 registered, depth 3 registered, depth 4 FWFT)
// with shared stimulus and checks each against a queue-based reference model.
module tb_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, push, pop;
  logic [15:0] wdata;
  logic [15:0] rd_a, rd_b, rd_c;
  logic [2:0]  cnt_a, cnt_c;
  logic [1:0]  cnt_b;
  logic [2:0]  full_v, empty_v, af_v, ae_v, ovf_v, unf_v;

  fifo_flex #(.DW(16), .DEPTH(4), .AF_LVL(3), .AE_LVL(1), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .write_data(wdata), .pop(pop),
    .read_data(rd_a), .full(full_v[0]), .empty(empty_v[0]), .almost_full(af_v[0]),
    .almost_empty(ae_v[0]), .count(cnt_a), .overflow(ovf_v[0]), .underflow(unf_v[0]));

  fifo_flex #(.DW(16), .DEPTH(3), .AE_LVL(1), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .write_data(wdata), .pop(pop),
    .read_data(rd_b), .full(full_v[1]), .empty(empty_v[1]), .almost_full(af_v[1]),
    .almost_empty(ae_v[1]), .count(cnt_b), .overflow(ovf_v[1]), .underflow(unf_v[1]));

  fifo_flex #(.DW(16), .DEPTH(4), .AF_LVL(3), .AE_LVL(1), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .write_data(wdata), .pop(pop),
    .read_data(rd_c), .full(full_v[2]), .empty(empty_v[2]), .almost_full(af_v[2]),
    .almost_empty(ae_v[2]), .count(cnt_c), .overflow(ovf_v[2]), .underflow(unf_v[2]));

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mq [3][$];
  int unsigned dep  [3] = '{4, 3, 4};
  int unsigned af_l [3] = '{3, 2, 3};
  bit          fw   [3] = '{1'b0, 1'b0, 1'b1};
  bit          m_ovf[3];
  bit          m_unf[3];
  logic [15:0] m_rd [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
      m_rd[i]  = '0;
    end
  endtask

  task automatic model_step(input bit c, input bit ps, input bit pp, input logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      bit          pop_ok, push_ok;
      logic [15:0] v;
      if (fw[i] && mq[i].size() > 0) m_rd[i] = mq[i][0];
      if (c) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end else begin
        pop_ok  = pp && (mq[i].size() > 0);
        push_ok = ps && ((mq[i].size() < dep[i]) || pop_ok);
        if (ps && !push_ok) m_ovf[i] = 1'b1;
        if (pp && mq[i].size() == 0) m_unf[i] = 1'b1;
        if (pop_ok) begin
          v = mq[i].pop_front();
          if (!fw[i]) m_rd[i] = v;
        end
        if (push_ok) mq[i].push_back(d);
      end
      if (fw[i] && mq[i].size() > 0) m_rd[i] = mq[i][0];
    end
  endtask

  task automatic check_all(input string where);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] r;
      logic [2:0]  c;
      int unsigned sz;
      case (i)
        0:       begin r = rd_a; c = cnt_a; end
        1:       begin r = rd_b; c = {1'b0, cnt_b}; end
        default: begin r = rd_c; c = cnt_c; end
      endcase
      sz = mq[i].size();
      chk($sformatf("%s/u%0d/count", where, i), {29'd0, c}, sz);
      chk($sformatf("%s/u%0d/full", where, i), {31'd0, full_v[i]}, {31'd0, sz == dep[i]});
      chk($sformatf("%s/u%0d/empty", where, i), {31'd0, empty_v[i]}, {31'd0, sz == 0});
      chk($sformatf("%s/u%0d/afull", where, i), {31'd0, af_v[i]}, {31'd0, sz >= af_l[i]});
      chk($sformatf("%s/u%0d/aempty", where, i), {31'd0, ae_v[i]}, {31'd0, sz <= 1});
      chk($sformatf("%s/u%0d/ovf", where, i), {31'd0, ovf_v[i]}, {31'd0, m_ovf[i]});
      chk($sformatf("%s/u%0d/unf", where, i), {31'd0, unf_v[i]}, {31'd0, m_unf[i]});
      chk($sformatf("%s/u%0d/rdata", where, i), {16'd0, r}, {16'd0, m_rd[i]});
    end
  endtask

  task automatic step(input string tag, input bit c, input bit ps, input bit pp,
                      input logic [15:0] d);
    clear = c;
    push  = ps;
    pop   = pp;
    wdata = d;
    @(posedge clk);
    model_step(c, ps, pp, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    for (int k = 1; k <= 5; k++) step("fill", 1'b0, 1'b1, 1'b0, 16'(k));
    chk("fill/a_full", {31'd0, full_v[0]}, 32'd1);
    chk("fill/a_count", {29'd0, cnt_a}, 32'd4);
    chk("fill/a_ovf", {31'd0, ovf_v[0]}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step("drain", 1'b0, 1'b0, 1'b1, '0);
      chk("drain/a_rdata", {16'd0, rd_a}, k);
    end
    step("pop_empty", 1'b0, 1'b0, 1'b1, '0);
    chk("pop_empty/a_unf", {31'd0, unf_v[0]}, 32'd1);
    chk("pop_empty/a_rdata", {16'd0, rd_a}, 32'd4);

    step("clr1", 1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 4; k++) step("refill", 1'b0, 1'b1, 1'b0, 16'(k));
    step("pass", 1'b0, 1'b1, 1'b1, 16'd9);
    chk("pass/a_rdata", {16'd0, rd_a}, 32'd1);
    chk("pass/a_count", {29'd0, cnt_a}, 32'd4);
    chk("pass/a_ovf", {31'd0, ovf_v[0]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_seq [4] = '{16'd2, 16'd3, 16'd4, 16'd9};
      step("pass_drain", 1'b0, 1'b0, 1'b1, '0);
      chk("pass_drain/a_rdata", {16'd0, rd_a}, {16'd0, exp_seq[k]});
    end

    step("clr2", 1'b1, 1'b0, 1'b0, '0);
    step("wrap_pre", 1'b0, 1'b1, 1'b0, 16'd10);
    step("wrap_pre", 1'b0, 1'b1, 1'b0, 16'd11);
    for (int k = 12; k <= 19; k++) begin
      step("wrap", 1'b0, 1'b1, 1'b1, 16'(k));
      chk("wrap/b_order", {16'd0, rd_b}, k - 2);
    end
    for (int k = 18; k <= 19; k++) begin
      step("wrap_tail", 1'b0, 1'b0, 1'b1, '0);
      chk("wrap/b_order", {16'd0, rd_b}, k);
    end

    step("clr3", 1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 5; k++) step("ovf_fill", 1'b0, 1'b1, 1'b0, 16'(k + 32));
    step("ovf_pop", 1'b0, 1'b0, 1'b1, '0);
    step("clr_push", 1'b1, 1'b1, 1'b0, 16'h55);
    chk("clr_push/a_count", {29'd0, cnt_a}, 32'd0);
    chk("clr_push/a_empty", {31'd0, empty_v[0]}, 32'd1);
    chk("clr_push/a_ovf", {31'd0, ovf_v[0]}, 32'd0);
    for (int k = 1; k <= 3; k++) step("pre_rst", 1'b0, 1'b1, 1'b0, 16'(k + 64));
    push = 1'b0;
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst/a_rdata", {16'd0, rd_a}, 32'd0);
    chk("async_rst/c_count", {29'd0, cnt_c}, 32'd0);
    #2 rst = 1'b1;

    step("fwft_push", 1'b0, 1'b1, 1'b0, 16'd7);
    chk("fwft_push/c_rdata", {16'd0, rd_c}, 32'd7);
    step("fwft_pop", 1'b0, 1'b0, 1'b1, '0);
    chk("fwft_pop/c_empty", {31'd0, empty_v[2]}, 32'd1);
    chk("fwft_pop/c_rdata", {16'd0, rd_c}, 32'd7);
    step("pushpop_empty", 1'b0, 1'b1, 1'b1, 16'h1234);

    for (int n = 0; n < 400; n++) begin
      bit c, ps, pp;
      int unsigned bias;
      bias = (n / 50) % 3;
      c  = ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5)));
      pp = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5)));
      step("rand", c, ps, pp, 16'($urandom));
    end

    clear = 1'b0; push = 1'b0; pop = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
